sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 94 +++++++++
 tb/tb_sram_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Single-port SRAM-style slave: byte-writable RAM plus a small config space
// holding an LED register and a free-running, writable 32-bit timer.
module sram_responder #(
  parameter int          ADDR_W  = 10,
  parameter logic [15:0] CONF_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  output logic [31:0] timer
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic              ready_reg;
  logic              is_conf;
  logic              led_hit;
  logic              timer_hit;
  logic              accept;
  logic              ram_we;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       conf_rdata;
  logic [31:0]       timer_inc;
  logic [31:0]       timer_next;
  logic [15:0]       led_next;
  logic              unused_addr_bits;

  assign unused_addr_bits = &{1'b0, sram_addr[1:0]};

  assign is_conf   = (sram_addr[31:16] == CONF_HI);
  assign led_hit   = is_conf && (sram_addr[15:0] == 16'hf000);
  assign timer_hit = is_conf && (sram_addr[15:0] == 16'he000);
  assign word_idx  = sram_addr[ADDR_W+1:2];

  // ready_reg drops any request seen on the first edge after reset release.
  assign accept = sram_en && ready_reg;
  assign ram_we = accept && !is_conf;

  always_comb begin
    conf_rdata = 32'h0;
    if (led_hit)
      conf_rdata = {16'h0, led};
    else if (timer_hit)
      conf_rdata = timer;
  end

  assign timer_inc = timer + 32'd1;

  // Written timer lanes override the incremented value lane by lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_timer_lane
      assign timer_next[8*gi +: 8] = (accept && timer_hit && sram_wen[gi])
                                     ? sram_wdata[8*gi +: 8]
                                     : timer_inc[8*gi +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_led_lane
      assign led_next[8*gi +: 8] = (accept && led_hit && sram_wen[gi])
                                   ? sram_wdata[8*gi +: 8]
                                   : led[8*gi +: 8];
    end
  endgenerate

  // RAM storage has no reset so contents survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_wen[i])
          mem[word_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_reg  <= 1'b0;
      sram_rdata <= 32'h0;
      led        <= 16'h0;
      timer      <= 32'h0;
    end else begin
      ready_reg <= 1'b1;
      timer     <= timer_next;
      led       <= led_next;
      if (accept)
        sram_rdata <= is_conf ? conf_rdata : mem[word_idx];
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: RAM byte writes, read-first, aliasing,
// LED/timer config registers, rdata hold and asynchronous reset behaviour.
module tb_sram_responder;

  logic        clk;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [15:0] led;
  logic [31:0] timer;

  int checks   = 0;
  int failures = 0;

  sram_responder #(.ADDR_W(10), .CONF_HI(16'hbfaf)) dut (
    .clk        (clk),
    .rst        (rst),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .led        (led),
    .timer      (timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one request, let one rising edge take it, return 1ns after the edge.
  task automatic req(input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata);
    sram_en    = en;
    sram_wen   = wen;
    sram_addr  = addr;
    sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    sram_en    = 1'b0;
    sram_wen   = 4'h0;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    #2;
    check("rst_rdata", sram_rdata, 32'h0);
    check("rst_led",   {16'h0, led}, 32'h0);
    check("rst_timer", timer, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    req(1'b0, 4'h0, 32'h0, 32'h0);

    // Full-word write then read
    req(1'b1, 4'hf, 32'h0000_0010, 32'h1122_3344);
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("rd_full", sram_rdata, 32'h1122_3344);

    // Partial write with read-first data, then readback and alias
    req(1'b1, 4'b0101, 32'h0000_0010, 32'haabb_ccdd);
    check("read_first", sram_rdata, 32'h1122_3344);
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("rd_partial", sram_rdata, 32'h11bb_33dd);
    req(1'b1, 4'h0, 32'h0000_1010, 32'h0);
    check("rd_alias", sram_rdata, 32'h11bb_33dd);

    // LED register; RAM word 0 aliases the LED offset's low bits
    req(1'b1, 4'hf, 32'h0000_0000, 32'h0bad_f00d);
    req(1'b1, 4'h3, 32'hbfaf_f000, 32'h0000_00a5);
    check("led_wr", {16'h0, led}, 32'h0000_00a5);
    req(1'b1, 4'h0, 32'hbfaf_f000, 32'h0);
    check("led_rd", sram_rdata, 32'h0000_00a5);
    req(1'b1, 4'h0, 32'h0000_0000, 32'h0);
    check("ram_after_cf", sram_rdata, 32'h0bad_f00d);
    req(1'b1, 4'b0010, 32'hbfaf_f000, 32'h0000_3c00);
    check("led_lane1", {16'h0, led}, 32'h0000_3ca5);

    // Unmapped config offset
    req(1'b1, 4'hf, 32'hbfaf_0004, 32'hffff_ffff);
    req(1'b1, 4'h0, 32'hbfaf_0004, 32'h0);
    check("unmapped_rd", sram_rdata, 32'h0);
    check("led_kept", {16'h0, led}, 32'h0000_3ca5);

    // Timer write and wrap
    req(1'b1, 4'hf, 32'hbfaf_e000, 32'hffff_fffe);
    check("timer_wr", timer, 32'hffff_fffe);
    req(1'b0, 4'h0, 32'h0, 32'h0);
    check("timer_t1", timer, 32'hffff_ffff);
    req(1'b0, 4'h0, 32'h0, 32'h0);
    check("timer_t2", timer, 32'h0000_0000);
    req(1'b0, 4'h0, 32'h0, 32'h0);
    check("timer_t3", timer, 32'h0000_0001);
    req(1'b1, 4'b0001, 32'hbfaf_e000, 32'h0000_0055);
    check("timer_lane0", timer, 32'h0000_0055);
    req(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
    check("timer_rd", sram_rdata, 32'h0000_0055);
    check("timer_post", timer, 32'h0000_0056);

    // rdata holds while en is low
    req(1'b1, 4'hf, 32'h0000_0040, 32'hdead_beef);
    req(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    check("rd_beef", sram_rdata, 32'hdead_beef);
    for (int i = 0; i < 5; i++) begin
      req(1'b0, 4'h0, 32'h0000_0040, 32'h0);
      check("rdata_hold", sram_rdata, 32'hdead_beef);
    end

    // Asynchronous reset mid-burst
    req(1'b1, 4'hf, 32'h0000_0020, 32'hcafe_f00d);
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    sram_addr = 32'h0000_0040;
    #3 rst = 1'b0;
    #1;
    check("arst_rdata", sram_rdata, 32'h0);
    check("arst_led",   {16'h0, led}, 32'h0);
    check("arst_timer", timer, 32'h0);
    sram_en    = 1'b1;
    sram_wen   = 4'hf;
    sram_addr  = 32'h0000_0020;
    sram_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    check("in_rst_rdata", sram_rdata, 32'h0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("release_drop", sram_rdata, 32'h0);
    req(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    check("ram_kept_20", sram_rdata, 32'hcafe_f00d);
    req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("ram_kept_10", sram_rdata, 32'h11bb_33dd);
    req(1'b0, 4'h0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
